// File: rtl/n_clic_top.sv
// ---------------------------------------------------------------------------
// n_clic_top - nested core-local interrupt controller (CLIC-style)
//
// Holds one config word per interrupt line (pending, enable, priority).
// Each word sits in CSR space at CfgAddrBot+k and is accessed through the
// core's general CSR interface with RW/RS/RC semantics. The block arbitrates
// pending+enabled lines and presents the registered winner to the core.
//
// Optional feature macro: NCLIC_VECTOR_TABLE_EN
//   Adds a vector-base CSR at CfgAddrBot+NoInterrupts and the output
//   o_irq_vector = base + 4*o_irq_id, registered alongside o_irq_*.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   csr_enable   in   CSR access strobe
//   i_csr_addr   in   CSR address
//   csr_op       in   CSR operation (RW/RS/RC and immediate forms)
//   rs1_zimm     in   rs1 index / zero-extended immediate
//   rs1_data     in   rs1 value for register forms
//   i_irq        in   level interrupt sources, bit k = line k
//   i_irq_ack    in   core claims the current winner
//   o_csr_hit    out  address decodes to one of this block's CSRs
//   o_csr_rdata  out  pre-write value at i_csr_addr, 0 on miss
//   o_irq_valid  out  an enabled, pending line exists
//   o_irq_id     out  winning line id
//   o_irq_vector out  vector address of winner (feature macro only)
//   o_irq_prio   out  winning line priority
// ---------------------------------------------------------------------------
module n_clic_top #(
    parameter int unsigned NoInterrupts = 8,
    parameter int unsigned CfgAddrBot   = 0,
    parameter int unsigned PrioBits     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    csr_enable,
    input  logic [11:0]             i_csr_addr,
    input  logic [2:0]              csr_op,
    input  logic [4:0]              rs1_zimm,
    input  logic [31:0]             rs1_data,
    input  logic [NoInterrupts-1:0] i_irq,
    input  logic                    i_irq_ack,
    output logic                    o_csr_hit,
    output logic [31:0]             o_csr_rdata,
    output logic                    o_irq_valid,
    output logic [4:0]              o_irq_id,
`ifdef NCLIC_VECTOR_TABLE_EN
    output logic [31:0]             o_irq_vector,
`endif
    output logic [PrioBits-1:0]     o_irq_prio
);

    localparam int unsigned CfgW = PrioBits + 2;

    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_op_t;

    typedef struct packed {
        logic [PrioBits-1:0] prio;
        logic                en;
        logic                pend;
    } int_config_t;

    int_config_t [NoInterrupts-1:0] cfg_q, cfg_d;

    logic                irq_valid_q, irq_valid_d;
    logic [4:0]          irq_id_q, irq_id_d;
    logic [PrioBits-1:0] irq_prio_q, irq_prio_d;

    logic [NoInterrupts-1:0] line_sel;
    logic                    cfg_hit;
    int_config_t             rd_cfg;
    logic [31:0]             old_word;
    logic [31:0]             src;
    logic [31:0]             wdata;
    logic                    wr_req;
    logic                    wr_en;
    logic                    ack_fire;
    csr_op_t                 op;

    // ---------------- address decode / read path ----------------
    always_comb begin
        line_sel = '0;
        rd_cfg   = '0;
        for (int unsigned k = 0; k < NoInterrupts; k++) begin
            line_sel[k] = (i_csr_addr == 12'(CfgAddrBot + k));
            if (line_sel[k]) rd_cfg = cfg_q[k];
        end
    end

    assign cfg_hit = |line_sel;

`ifdef NCLIC_VECTOR_TABLE_EN
    logic [31:2] base_q, base_d;
    logic [31:0] vec_q, vec_d;
    logic        vec_sel;

    assign vec_sel   = (i_csr_addr == 12'(CfgAddrBot + NoInterrupts));
    assign o_csr_hit = cfg_hit | vec_sel;
    assign old_word  = vec_sel ? {base_q, 2'b00}
                               : {{(32-CfgW){1'b0}}, rd_cfg};
`else
    assign o_csr_hit = cfg_hit;
    assign old_word  = {{(32-CfgW){1'b0}}, rd_cfg};
`endif

    assign o_csr_rdata = old_word;

    // ---------------- write path ----------------
    assign op  = csr_op_t'(csr_op);
    // csr_op[2] marks the immediate forms
    assign src = csr_op[2] ? {27'b0, rs1_zimm} : rs1_data;

    always_comb begin
        wr_req = 1'b0;
        wdata  = old_word;
        case (op)
            CSRRW, CSRRWI: begin
                wr_req = 1'b1;
                wdata  = src;
            end
            // set/clear with x0 / zimm=0 are pure reads
            CSRRS, CSRRSI: begin
                wr_req = (rs1_zimm != 5'd0);
                wdata  = old_word | src;
            end
            CSRRC, CSRRCI: begin
                wr_req = (rs1_zimm != 5'd0);
                wdata  = old_word & ~src;
            end
            default: ;
        endcase
    end

    assign wr_en = csr_enable && o_csr_hit && wr_req;

    // Bits outside the implemented fields are dropped on write.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // ---------------- config next state ----------------
    // Priority order per line: ack clear < CSR write < level set.
    assign ack_fire = i_irq_ack && irq_valid_q;

    always_comb begin
        cfg_d = cfg_q;
        for (int unsigned k = 0; k < NoInterrupts; k++) begin
            if (ack_fire && (irq_id_q == 5'(k))) cfg_d[k].pend = 1'b0;
            if (wr_en && line_sel[k])            cfg_d[k] = int_config_t'(wdata[CfgW-1:0]);
            cfg_d[k].pend = cfg_d[k].pend | i_irq[k];
        end
    end

    // ---------------- arbitration ----------------
    // Strict '>' keeps the earlier (lower) id on priority ties.
    always_comb begin
        irq_valid_d = 1'b0;
        irq_id_d    = '0;
        irq_prio_d  = '0;
        for (int unsigned k = 0; k < NoInterrupts; k++) begin
            if (cfg_q[k].pend && cfg_q[k].en &&
                (!irq_valid_d || (cfg_q[k].prio > irq_prio_d))) begin
                irq_valid_d = 1'b1;
                irq_id_d    = 5'(k);
                irq_prio_d  = cfg_q[k].prio;
            end
        end
    end

`ifdef NCLIC_VECTOR_TABLE_EN
    always_comb begin
        base_d = base_q;
        if (wr_en && vec_sel) base_d = wdata[31:2];
        vec_d = {base_q, 2'b00} + {25'b0, irq_id_d, 2'b00};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            vec_q  <= '0;
        end else begin
            base_q <= base_d;
            vec_q  <= vec_d;
        end
    end

    assign o_irq_vector = vec_q;
`endif

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q       <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            irq_prio_q  <= '0;
        end else begin
            cfg_q       <= cfg_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            irq_prio_q  <= irq_prio_d;
        end
    end

    assign o_irq_valid = irq_valid_q;
    assign o_irq_id    = irq_id_q;
    assign o_irq_prio  = irq_prio_q;

endmodule

// File: tb/tb_n_clic_top.sv
// Testbench for n_clic_top: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the controller.
module tb_n_clic_top;

    localparam int N   = 8;
    localparam int BOT = 0;
    localparam int PB  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [4:0]  zimm;
    logic [31:0] rs1d;
    logic [N-1:0] irq;
    logic        ack;
    logic        hit;
    logic [31:0] rdata;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic [PB-1:0] irq_prio;
`ifdef NCLIC_VECTOR_TABLE_EN
    logic [31:0] irq_vector;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    n_clic_top #(.NoInterrupts(N), .CfgAddrBot(BOT), .PrioBits(PB)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .csr_enable  (csr_en),
        .i_csr_addr  (csr_addr),
        .csr_op      (csr_op),
        .rs1_zimm    (zimm),
        .rs1_data    (rs1d),
        .i_irq       (irq),
        .i_irq_ack   (ack),
        .o_csr_hit   (hit),
        .o_csr_rdata (rdata),
        .o_irq_valid (irq_valid),
        .o_irq_id    (irq_id),
`ifdef NCLIC_VECTOR_TABLE_EN
        .o_irq_vector(irq_vector),
`endif
        .o_irq_prio  (irq_prio)
    );

    // ---------------- behavioural model ----------------
    int          m_pend[N];
    int          m_en[N];
    int          m_prio[N];
    bit          m_valid;
    int          m_id;
    int          m_prio_o;
    logic [31:0] m_base;
    logic [31:0] m_vec;

    function automatic bit mhit(int a);
        bit h;
        h = (a >= BOT) && (a < BOT + N);
`ifdef NCLIC_VECTOR_TABLE_EN
        if (a == BOT + N) h = 1'b1;
`endif
        return h;
    endfunction

    function automatic logic [31:0] mread(int a);
        if ((a >= BOT) && (a < BOT + N))
            return 32'(m_prio[a-BOT] * 4 + m_en[a-BOT] * 2 + m_pend[a-BOT]);
`ifdef NCLIC_VECTOR_TABLE_EN
        if (a == BOT + N) return m_base;
`endif
        return 32'd0;
    endfunction

    function automatic void mreset();
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 0; m_en[k] = 0; m_prio[k] = 0;
        end
        m_valid = 0; m_id = 0; m_prio_o = 0; m_base = '0; m_vec = '0;
    endfunction

    // Advance one clock: evaluate the spec rules on the current inputs,
    // update the model, then move to 1ns after the rising edge.
    task automatic step();
        int a, bp, bid;
        bit wr, ackf, bv;
        logic [31:0] s, old, nw;
        a   = int'(csr_addr);
        s   = csr_op[2] ? {27'b0, zimm} : rs1d;
        old = mread(a);
        wr  = 0;
        nw  = old;
        if (csr_en && mhit(a)) begin
            case (csr_op)
                3'd1, 3'd5: begin wr = 1; nw = s; end
                3'd2, 3'd6: begin wr = (zimm != 0); nw = old | s; end
                3'd3, 3'd7: begin wr = (zimm != 0); nw = old & ~s; end
                default: ;
            endcase
        end
        ackf = ack && m_valid;
        // highest priority first, then the lowest id holding it
        bp = -1;
        for (int k = 0; k < N; k++)
            if (m_pend[k] != 0 && m_en[k] != 0 && m_prio[k] > bp) bp = m_prio[k];
        bv  = (bp >= 0);
        bid = 0;
        if (bv)
            for (int k = N - 1; k >= 0; k--)
                if (m_pend[k] != 0 && m_en[k] != 0 && m_prio[k] == bp) bid = k;
        m_vec = m_base + 32'(4 * bid);
        if (ackf) m_pend[m_id] = 0;
        if (wr) begin
            if ((a >= BOT) && (a < BOT + N)) begin
                m_pend[a-BOT] = int'(nw[0]);
                m_en[a-BOT]   = int'(nw[1]);
                m_prio[a-BOT] = int'(nw >> 2) % (1 << PB);
            end else begin
                m_base = nw & 32'hFFFF_FFFC;
            end
        end
        for (int k = 0; k < N; k++) if (irq[k]) m_pend[k] = 1;
        m_valid  = bv;
        m_id     = bv ? bid : 0;
        m_prio_o = bv ? bp : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit en, int a, int op, int z, logic [31:0] d);
        csr_en   = en;
        csr_addr = 12'(a);
        csr_op   = 3'(op);
        zimm     = 5'(z);
        rs1d     = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        irq = '0; ack = 1'b0;
        mreset();
        #1;
        for (int a = 0; a < N; a++) begin
            csr_addr = 12'(a);
            #1;
            n_chk++;
            if (rdata !== 32'd0 || hit !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d got rdata=%h hit=%b want 0/1", a, rdata, hit);
            end
        end
        n_chk++;
        if (irq_valid !== 1'b0 || irq_id !== 5'd0 || irq_prio !== '0) begin
            n_fail++;
            $display("FAIL reset_irq got v=%b id=%0d p=%0d want 0/0/0", irq_valid, irq_id, irq_prio);
        end
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rw_basic();
        drive(1, 3, 1, 0, 32'hF);
        #1;
        n_chk++;
        if (rdata !== 32'd0 || hit !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_prewrite got rdata=%h hit=%b want 0/1", rdata, hit);
        end
        step();
        csr_en = 1'b0;
        #1;
        n_chk++;
        if (rdata !== 32'hF) begin
            n_fail++;
            $display("FAIL rw_readback got %h want 0000000f", rdata);
        end
        n_chk++;
        if (irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_latency got valid=%b want 0", irq_valid);
        end
        step();
        n_chk++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd3 || irq_prio !== 3'd3) begin
            n_fail++;
            $display("FAIL rw_winner got v=%b id=%0d p=%0d want 1/3/3", irq_valid, irq_id, irq_prio);
        end
    endtask

    task automatic test_no_enable();
        for (int a = 4; a < 16; a++) begin
            drive(0, a, 1, 0, 32'h10 + 32'(a));
            #1;
            n_chk++;
            if (hit !== mhit(a) || rdata !== mread(a)) begin
                n_fail++;
                $display("FAIL noen_read addr=%0d got hit=%b rdata=%h want %b/%h", a, hit, rdata, mhit(a), mread(a));
            end
            step();
        end
        csr_addr = 12'd3;
        #1;
        n_chk++;
        if (rdata !== 32'hF) begin
            n_fail++;
            $display("FAIL noen_keep got %h want 0000000f", rdata);
        end
    endtask

    task automatic test_arbitration();
        drive(1, 1, 1, 0, 32'h17); step();
        drive(1, 6, 1, 0, 32'h17); step();
        csr_en = 1'b0;
        step();
        n_chk++;
        if (irq_id !== 5'd1 || irq_prio !== 3'd5 || irq_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_tie got v=%b id=%0d p=%0d want 1/1/5", irq_valid, irq_id, irq_prio);
        end
        ack = 1'b1; step(); ack = 1'b0;
        csr_addr = 12'd1;
        #1;
        n_chk++;
        if (rdata !== 32'h16) begin
            n_fail++;
            $display("FAIL arb_ack_clear got %h want 00000016", rdata);
        end
        step();
        n_chk++;
        if (irq_id !== 5'd6 || irq_prio !== 3'd5) begin
            n_fail++;
            $display("FAIL arb_next got id=%0d p=%0d want 6/5", irq_id, irq_prio);
        end
    endtask

    task automatic test_clear_imm();
        drive(1, 1, 1, 0, 32'h0); step();
        drive(1, 6, 1, 0, 32'h0); step();
        csr_en = 1'b0; step();
        n_chk++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd3) begin
            n_fail++;
            $display("FAIL clr_pre got v=%b id=%0d want 1/3", irq_valid, irq_id);
        end
        drive(1, 3, 7, 2, 32'hFFFF_FFFF); step();
        csr_en = 1'b0;
        #1;
        n_chk++;
        if (rdata !== 32'hD || irq_valid !== 1'(m_valid)) begin
            n_fail++;
            $display("FAIL clr_rci got rdata=%h v=%b want 0000000d/%b", rdata, irq_valid, m_valid);
        end
        step();
        n_chk++;
        if (irq_valid !== 1'b0 || irq_id !== 5'd0 || irq_prio !== 3'd0) begin
            n_fail++;
            $display("FAIL clr_drop got v=%b id=%0d p=%0d want 0/0/0", irq_valid, irq_id, irq_prio);
        end
        drive(1, 3, 6, 0, 32'hFFFF_FFFF); step();
        drive(1, 3, 2, 0, 32'hFFFF_FFFF); step();
        csr_en = 1'b0;
        #1;
        n_chk++;
        if (rdata !== 32'hD) begin
            n_fail++;
            $display("FAIL clr_zero_nowrite got %h want 0000000d", rdata);
        end
        drive(1, 3, 3, 1, 32'h1); step();
        csr_en = 1'b0;
        #1;
        n_chk++;
        if (rdata !== 32'hC) begin
            n_fail++;
            $display("FAIL clr_rc_reg got %h want 0000000c", rdata);
        end
    endtask

    task automatic test_same_cycle();
        drive(1, 2, 1, 0, 32'h6); step();
        csr_en = 1'b0;
        irq = N'(4); step(); irq = '0;
        step();
        n_chk++;
        if (irq_valid !== 1'b1 || irq_id !== 5'd2 || irq_prio !== 3'd1) begin
            n_fail++;
            $display("FAIL same_win got v=%b id=%0d p=%0d want 1/2/1", irq_valid, irq_id, irq_prio);
        end
        ack = 1'b1; irq = N'(4); step(); ack = 1'b0; irq = '0;
        csr_addr = 12'd2;
        #1;
        n_chk++;
        if (rdata !== 32'h7) begin
            n_fail++;
            $display("FAIL same_set_wins got %h want 00000007", rdata);
        end
        ack = 1'b1; drive(1, 2, 1, 0, 32'h7); step(); ack = 1'b0;
        csr_en = 1'b0;
        #1;
        n_chk++;
        if (rdata !== 32'h7) begin
            n_fail++;
            $display("FAIL same_csr_wins got %h want 00000007", rdata);
        end
        drive(1, 2, 1, 0, 32'h0); step();
        drive(1, 0, 1, 0, 32'h1); step();
        csr_en = 1'b0; step();
        ack = 1'b1; step(); ack = 1'b0;
        csr_addr = 12'd0;
        #1;
        n_chk++;
        if (rdata !== 32'h1 || irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_ignored got rdata=%h v=%b want 00000001/0", rdata, irq_valid);
        end
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 400; i++) begin
            a = int'($urandom_range(0, N + 1));
            drive(($urandom_range(0, 1) == 1), a, int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)), $urandom);
            irq = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            ack = ($urandom_range(0, 3) == 0);
            #1;
            n_chk++;
            if (hit !== mhit(a) || rdata !== mread(a)) begin
                n_fail++;
                $display("FAIL rnd_read i=%0d addr=%0d got hit=%b rdata=%h want %b/%h", i, a, hit, rdata, mhit(a), mread(a));
            end
            step();
            n_chk++;
            if (irq_valid !== 1'(m_valid) || irq_id !== 5'(m_id) || irq_prio !== PB'(m_prio_o)) begin
                n_fail++;
                $display("FAIL rnd_irq i=%0d got v=%b id=%0d p=%0d want %b/%0d/%0d", i, irq_valid, irq_id, irq_prio, m_valid, m_id, m_prio_o);
            end
`ifdef NCLIC_VECTOR_TABLE_EN
            n_chk++;
            if (irq_vector !== m_vec) begin
                n_fail++;
                $display("FAIL rnd_vector i=%0d got %h want %h", i, irq_vector, m_vec);
            end
`endif
        end
        irq = '0; ack = 1'b0; csr_en = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        drive(1, 1, 1, 0, 32'h1F); step();
        drive(1, 5, 1, 0, 32'h1B);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        mreset();
        csr_en = 1'b0;
        for (int a = 0; a < N; a++) begin
            csr_addr = 12'(a);
            #1;
            n_chk++;
            if (rdata !== 32'd0) begin
                n_fail++;
                $display("FAIL midrst_read addr=%0d got %h want 0", a, rdata);
            end
        end
        n_chk++;
        if (irq_valid !== 1'b0 || irq_id !== 5'd0) begin
            n_fail++;
            $display("FAIL midrst_irq got v=%b id=%0d want 0/0", irq_valid, irq_id);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rw_basic();
        test_no_enable();
        test_arbitration();
        test_clear_imm();
        test_same_cycle();
        test_random();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
